user_axil_ctrl_regs: RTL and testbench

//   AXI4-Lite responder terminating shell_axil_ctrl inside the user partition; the shell is the initiator.

---
 rtl/user_axil_ctrl_regs_if.sv | 38 +++
 rtl/user_axil_ctrl_regs.sv | 233 +++++++++++++++++++++++
 tb/tb_user_axil_ctrl_regs.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/user_axil_ctrl_regs_if.sv
// AXI4-Lite bundle between the shell initiator (master) and the user register block (slave).
// Latency: none, this is only a signal bundle.
// Backpressure: plain valid/ready on all five channels; one transfer per handshake.
interface user_axil_ctrl_regs_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/user_axil_ctrl_regs.sv
// User-partition AXI4-Lite register block: ID/version, scratch, control, HBM thermal status, cycle counter.
// Latency: write response one cycle after AW+W commit; read data one cycle after AR handshake.
// Backpressure: one outstanding transaction per channel; B and R held stable until bready/rready.
// Ports: shell_axi_clk/shell_rstn (async active-low), shell_axil_ctrl (AXI4-Lite slave modport),
//        user_hbm_cattrip/user_hbm_temp_0/user_hbm_temp_1 (thermal inputs), user_ctrl (CONTROL[1:0]).
// CYCLE_INIT sets the counter reset value (0 in normal use).
module user_axil_ctrl_regs #(
  parameter logic [31:0] USER_ID      = 32'h5553_4552,
  parameter logic [31:0] USER_VERSION = 32'h0001_0000,
  parameter int          ADDR_WIDTH   = 32,
  parameter logic [63:0] CYCLE_INIT   = 64'd0
) (
  input  logic                        shell_axi_clk,
  input  logic                        shell_rstn,
  user_axil_ctrl_regs_if.slave        shell_axil_ctrl,
  input  logic                        user_hbm_cattrip,
  input  logic [6:0]                  user_hbm_temp_0,
  input  logic [6:0]                  user_hbm_temp_1,
  output logic [1:0]                  user_ctrl
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  w_state_t    w_state, w_next;
  r_state_t    r_state, r_next;
  logic        rst_done;

  logic        aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;
  logic        lat_aw, lat_w, ar_hs;
  logic [5:0]  aw_idx_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic        wr_en;
  logic [5:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [1:0]  bresp_q;

  logic [31:0] scratch;
  logic [1:0]  ctrl;
  logic        sticky;
  logic [6:0]  peak;
  logic [63:0] cycle_cnt;
  logic [31:0] cycle_snap;

  logic [5:0]  ar_idx;
  logic [31:0] rd_data, rdata_q;
  logic [1:0]  rd_resp, rresp_q;
  logic [6:0]  temp_max;

  // Address/prot bits outside [7:2] are deliberately ignored (aliasing is allowed).
  logic unused_bits;
  assign unused_bits = ^{shell_axil_ctrl.awprot, shell_axil_ctrl.arprot,
                         shell_axil_ctrl.awaddr[ADDR_WIDTH-1:8], shell_axil_ctrl.awaddr[1:0],
                         shell_axil_ctrl.araddr[ADDR_WIDTH-1:8], shell_axil_ctrl.araddr[1:0]};

  assign temp_max = (user_hbm_temp_0 > user_hbm_temp_1) ? user_hbm_temp_0 : user_hbm_temp_1;
  assign ar_idx   = shell_axil_ctrl.araddr[7:2];

  // Readies stay low until the first clock edge after reset release.
  always_ff @(posedge shell_axi_clk or negedge shell_rstn) begin
    if (!shell_rstn) rst_done <= 1'b0;
    else             rst_done <= 1'b1;
  end

  // ---------------- write channel FSM ----------------
  always_ff @(posedge shell_axi_clk or negedge shell_rstn) begin
    if (!shell_rstn) begin
      w_state  <= W_IDLE;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      w_state <= w_next;
      if (lat_aw) aw_idx_q <= shell_axil_ctrl.awaddr[7:2];
      if (lat_w) begin
        wdata_q <= shell_axil_ctrl.wdata;
        wstrb_q <= shell_axil_ctrl.wstrb;
      end
      if (wr_en) bresp_q <= (wr_idx > 6'd7) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_comb begin
    w_next  = w_state;
    aw_rdy  = 1'b0;
    w_rdy   = 1'b0;
    b_vld   = 1'b0;
    lat_aw  = 1'b0;
    lat_w   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = aw_idx_q;
    wr_data = wdata_q;
    wr_strb = wstrb_q;
    case (w_state)
      W_IDLE: begin
        aw_rdy = rst_done;
        w_rdy  = rst_done;
        if (shell_axil_ctrl.awvalid && aw_rdy && shell_axil_ctrl.wvalid && w_rdy) begin
          wr_en   = 1'b1;
          wr_idx  = shell_axil_ctrl.awaddr[7:2];
          wr_data = shell_axil_ctrl.wdata;
          wr_strb = shell_axil_ctrl.wstrb;
          w_next  = W_RESP;
        end else if (shell_axil_ctrl.awvalid && aw_rdy) begin
          lat_aw = 1'b1;
          w_next = W_HAVE_AW;
        end else if (shell_axil_ctrl.wvalid && w_rdy) begin
          lat_w  = 1'b1;
          w_next = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        w_rdy = 1'b1;
        if (shell_axil_ctrl.wvalid) begin
          wr_en   = 1'b1;
          wr_data = shell_axil_ctrl.wdata;
          wr_strb = shell_axil_ctrl.wstrb;
          w_next  = W_RESP;
        end
      end
      W_HAVE_W: begin
        aw_rdy = 1'b1;
        if (shell_axil_ctrl.awvalid) begin
          wr_en  = 1'b1;
          wr_idx = shell_axil_ctrl.awaddr[7:2];
          w_next = W_RESP;
        end
      end
      W_RESP: begin
        b_vld = 1'b1;
        if (shell_axil_ctrl.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign shell_axil_ctrl.awready = aw_rdy;
  assign shell_axil_ctrl.wready  = w_rdy;
  assign shell_axil_ctrl.bvalid  = b_vld;
  assign shell_axil_ctrl.bresp   = bresp_q;

  // ---------------- register file ----------------
  always_ff @(posedge shell_axi_clk or negedge shell_rstn) begin
    if (!shell_rstn) begin
      scratch   <= '0;
      ctrl      <= '0;
      sticky    <= 1'b0;
      peak      <= '0;
      cycle_cnt <= CYCLE_INIT;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (wr_en && wr_idx == 6'd2) begin
        for (int i = 0; i < 4; i++) begin
          if (wr_strb[i]) scratch[i*8 +: 8] <= wr_data[i*8 +: 8];
        end
      end
      if (wr_en && wr_idx == 6'd3) ctrl <= wr_data[1:0];
      // Live cattrip wins over a same-cycle write-1-to-clear.
      sticky <= user_hbm_cattrip | (sticky & ~(wr_en && wr_idx == 6'd4 && wr_data[1]));
      // Any write to HBM_TEMP restarts the peak from the current temperatures.
      if (wr_en && wr_idx == 6'd5) peak <= temp_max;
      else                         peak <= (peak > temp_max) ? peak : temp_max;
    end
  end

  assign user_ctrl = ctrl;

  // ---------------- read channel ----------------
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (ar_idx)
      6'd0: rd_data = USER_ID;
      6'd1: rd_data = USER_VERSION;
      6'd2: rd_data = scratch;
      6'd3: rd_data = {30'd0, ctrl};
      6'd4: rd_data = {30'd0, sticky, user_hbm_cattrip};
      6'd5: rd_data = {9'd0, peak, 1'b0, user_hbm_temp_1, 1'b0, user_hbm_temp_0};
      6'd6: rd_data = cycle_cnt[31:0];
      6'd7: rd_data = cycle_snap;
      default: rd_resp = RESP_SLVERR;
    endcase
  end

  always_comb begin
    r_next = r_state;
    ar_rdy = 1'b0;
    r_vld  = 1'b0;
    case (r_state)
      R_IDLE: begin
        ar_rdy = rst_done;
        if (shell_axil_ctrl.arvalid && ar_rdy) r_next = R_DATA;
      end
      R_DATA: begin
        r_vld = 1'b1;
        if (shell_axil_ctrl.rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign ar_hs = shell_axil_ctrl.arvalid && ar_rdy;

  // Read data is captured at the AR handshake edge, so a same-edge write is not yet visible.
  always_ff @(posedge shell_axi_clk or negedge shell_rstn) begin
    if (!shell_rstn) begin
      r_state    <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      cycle_snap <= '0;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        rdata_q <= rd_data;
        rresp_q <= rd_resp;
        if (ar_idx == 6'd6) cycle_snap <= cycle_cnt[63:32];
      end
    end
  end

  assign shell_axil_ctrl.arready = ar_rdy;
  assign shell_axil_ctrl.rvalid  = r_vld;
  assign shell_axil_ctrl.rdata   = rdata_q;
  assign shell_axil_ctrl.rresp   = rresp_q;

endmodule

// File: tb/tb_user_axil_ctrl_regs.sv
// Self-checking bench for user_axil_ctrl_regs: scoreboard queues hold expected B/R responses.
module tb_user_axil_ctrl_regs;
  localparam logic [63:0] CYC_INIT = 64'h0000_0000_FFFF_FFF0;
  localparam logic [31:0] ID_VAL   = 32'h5553_4552;
  localparam logic [31:0] VER_VAL  = 32'h0001_0000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cattrip;
  logic [6:0] temp0, temp1;
  logic [1:0] user_ctrl;

  int n_chk = 0;
  int n_pass = 0;
  logic [33:0] exp_r[$];
  logic [1:0]  exp_b[$];
  logic [63:0] tb_cnt;

  always #5 clk = ~clk;

  user_axil_ctrl_regs_if #(.ADDR_WIDTH(32)) axil ();

  user_axil_ctrl_regs #(.ADDR_WIDTH(32), .CYCLE_INIT(CYC_INIT)) dut (
    .shell_axi_clk    (clk),
    .shell_rstn       (rst_n),
    .shell_axil_ctrl  (axil),
    .user_hbm_cattrip (cattrip),
    .user_hbm_temp_0  (temp0),
    .user_hbm_temp_1  (temp1),
    .user_ctrl        (user_ctrl)
  );

  // Reference free-running counter.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cnt <= CYC_INIT;
    else        tb_cnt <= tb_cnt + 64'd1;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic axil_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_hold,
                            input logic [1:0] resp, input string name);
    int t = 0;
    bit aw_done = 0, w_done = 0, aw_hit, w_hit, stable = 1;
    logic [1:0] first, got;
    logic v;
    exp_b.push_back(resp);
    axil.awaddr = addr; axil.wdata = data; axil.wstrb = strb;
    while (!(aw_done && w_done) && t < 100) begin
      axil.awvalid = !aw_done && (t >= aw_dly);
      axil.wvalid  = !w_done && (t >= w_dly);
      @(negedge clk);
      aw_hit = axil.awvalid && axil.awready;
      w_hit  = axil.wvalid && axil.wready;
      step();
      if (aw_hit) aw_done = 1;
      if (w_hit)  w_done = 1;
      t++;
    end
    axil.awvalid = 0; axil.wvalid = 0;
    n_chk++;
    if (!(aw_done && w_done) || axil.bvalid !== 1'b1)
      $display("FAIL %s bvalid_after_commit: got %b want 1 (aw=%0d w=%0d)", name, axil.bvalid, aw_done, w_done);
    else n_pass++;
    first = axil.bresp;
    for (int i = 0; i < b_hold; i++) begin
      @(negedge clk);
      if (axil.bvalid !== 1'b1 || axil.bresp !== first) stable = 0;
      step();
    end
    if (b_hold > 0) begin
      n_chk++;
      if (!stable) $display("FAIL %s b_hold_stable: got unstable want stable", name);
      else n_pass++;
    end
    axil.bready = 1;
    @(negedge clk);
    got = axil.bresp; v = axil.bvalid;
    step();
    axil.bready = 0;
    n_chk++;
    if (exp_b.size() == 0) $display("FAIL %s bresp: scoreboard empty", name);
    else begin
      logic [1:0] e;
      e = exp_b.pop_front();
      if (v !== 1'b1 || got !== e) $display("FAIL %s bresp: got v=%b %b want v=1 %b", name, v, got, e);
      else n_pass++;
    end
  endtask

  task automatic axil_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                           input int r_hold, input bit use_cnt, input string name);
    int t = 0;
    bit done = 0, hit, stable = 1;
    logic [63:0] cnt_s;
    logic [31:0] first, gd;
    logic [1:0] gr;
    logic v;
    if (!use_cnt) exp_r.push_back({data, resp});
    axil.araddr = addr; axil.arvalid = 1;
    while (!done && t < 100) begin
      @(negedge clk);
      hit = axil.arvalid && axil.arready;
      cnt_s = tb_cnt;
      step();
      if (hit) begin
        done = 1;
        if (use_cnt) exp_r.push_back({cnt_s[31:0], 2'b00});
      end
      t++;
    end
    axil.arvalid = 0;
    n_chk++;
    if (!done || axil.rvalid !== 1'b1)
      $display("FAIL %s rvalid_next_cycle: got %b want 1 (ar_done=%0d)", name, axil.rvalid, done);
    else n_pass++;
    first = axil.rdata;
    for (int i = 0; i < r_hold; i++) begin
      @(negedge clk);
      if (axil.rvalid !== 1'b1 || axil.rdata !== first) stable = 0;
      step();
    end
    if (r_hold > 0) begin
      n_chk++;
      if (!stable) $display("FAIL %s r_hold_stable: got unstable want stable", name);
      else n_pass++;
    end
    axil.rready = 1;
    @(negedge clk);
    gd = axil.rdata; gr = axil.rresp; v = axil.rvalid;
    step();
    axil.rready = 0;
    n_chk++;
    if (exp_r.size() == 0) $display("FAIL %s rdata: scoreboard empty", name);
    else begin
      logic [33:0] e;
      e = exp_r.pop_front();
      if (v !== 1'b1 || {gd, gr} !== e)
        $display("FAIL %s rdata: got v=%b %h/%b want v=1 %h/%b", name, v, gd, gr, e[33:2], e[1:0]);
      else n_pass++;
    end
  endtask

  task automatic bus_idle();
    axil.awaddr = '0; axil.awprot = '0; axil.awvalid = 0;
    axil.wdata = '0; axil.wstrb = '0; axil.wvalid = 0; axil.bready = 0;
    axil.araddr = '0; axil.arprot = '0; axil.arvalid = 0; axil.rready = 0;
  endtask

  task automatic test_reset();
    bus_idle();
    cattrip = 0; temp0 = 0; temp1 = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid} !== 5'b0 ||
        axil.bresp !== 2'b0 || axil.rresp !== 2'b0 || axil.rdata !== 32'd0 || user_ctrl !== 2'b0)
      $display("FAIL reset_outputs: got rdy/vld=%b bresp=%b rresp=%b rdata=%h ctrl=%b want all 0",
               {axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid},
               axil.bresp, axil.rresp, axil.rdata, user_ctrl);
    else n_pass++;
    @(posedge clk); #1 rst_n = 1;
    #1;
    n_chk++;
    if (axil.awready !== 1'b0) $display("FAIL ready_before_first_clock: got %b want 0", axil.awready);
    else n_pass++;
    @(posedge clk); #1;
    n_chk++;
    if ({axil.awready, axil.wready, axil.arready} !== 3'b111)
      $display("FAIL ready_after_first_clock: got %b want 111", {axil.awready, axil.wready, axil.arready});
    else n_pass++;
  endtask

  task automatic test_id_version();
    axil_read(32'h00, ID_VAL, 2'b00, 0, 0, "read_id");
    axil_read(32'h04, VER_VAL, 2'b00, 0, 0, "read_version");
    axil_read(32'h104, VER_VAL, 2'b00, 0, 0, "read_alias_version");
    axil_read(32'h08, 32'h0, 2'b00, 0, 0, "scratch_reset");
  endtask

  task automatic test_scratch();
    axil_write(32'h08, 32'hDEAD_BEEF, 4'b0101, 0, 3, 0, 2'b00, "scratch_aw_first");
    axil_read(32'h08, 32'h00AD_00EF, 2'b00, 0, 0, "scratch_strobe");
  endtask

  task automatic test_back_to_back();
    axil_write(32'h08, 32'h1122_3344, 4'hF, 2, 0, 0, 2'b00, "scratch_w_first");
    axil_read(32'h08, 32'h1122_3344, 2'b00, 0, 0, "scratch_w_first_rd");
    axil_write(32'h08, 32'hAA00_0000, 4'b1000, 0, 0, 3, 2'b00, "scratch_same_cycle");
    axil_read(32'h08, 32'hAA22_3344, 2'b00, 0, 0, "scratch_same_cycle_rd");
  endtask

  task automatic test_control();
    axil_write(32'h0C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 2'b00, "ctrl_write");
    n_chk++;
    if (user_ctrl !== 2'b11) $display("FAIL user_ctrl_port: got %b want 11", user_ctrl);
    else n_pass++;
    axil_read(32'h0C, 32'h3, 2'b00, 0, 0, "ctrl_read");
    axil_write(32'h00, 32'h1234_5678, 4'hF, 0, 0, 0, 2'b00, "ro_write_okay");
    axil_read(32'h00, ID_VAL, 2'b00, 0, 0, "ro_unchanged");
  endtask

  task automatic test_cattrip();
    cattrip = 1; step(); cattrip = 0; step();
    axil_read(32'h10, 32'h2, 2'b00, 0, 0, "sticky_after_pulse");
    cattrip = 1;
    axil_write(32'h10, 32'h2, 4'hF, 0, 0, 0, 2'b00, "w1c_while_live");
    axil_read(32'h10, 32'h3, 2'b00, 0, 0, "sticky_set_wins");
    cattrip = 0;
    axil_write(32'h10, 32'h2, 4'hF, 0, 0, 0, 2'b00, "w1c_clear");
    axil_read(32'h10, 32'h0, 2'b00, 0, 0, "sticky_cleared");
  endtask

  task automatic test_temp();
    temp0 = 7'd40; temp1 = 7'd55; step(); step();
    temp1 = 7'd30; step(); step();
    axil_read(32'h14, (32'd55 << 16) | (32'd30 << 8) | 32'd40, 2'b00, 0, 0, "temp_peak");
    axil_write(32'h14, 32'h0, 4'hF, 0, 0, 0, 2'b00, "temp_peak_reload");
    axil_read(32'h14, (32'd40 << 16) | (32'd30 << 8) | 32'd40, 2'b00, 0, 0, "temp_peak_reloaded");
  endtask

  task automatic test_decode_err();
    axil_read(32'h20, 32'h0, 2'b10, 0, 0, "read_unmapped");
    axil_write(32'h3C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 2'b10, "write_unmapped");
    axil_read(32'h08, 32'hAA22_3344, 2'b00, 0, 0, "unmapped_scratch_intact");
    axil_read(32'h0C, 32'h3, 2'b00, 0, 0, "unmapped_ctrl_intact");
  endtask

  task automatic test_rw_collision();
    logic [31:0] gd; logic [1:0] gr, gb; logic rv, bv; bit hit;
    exp_r.push_back({32'hAA22_3344, 2'b00});
    exp_b.push_back(2'b00);
    axil.awaddr = 32'h08; axil.wdata = 32'h5555_5555; axil.wstrb = 4'hF; axil.araddr = 32'h08;
    axil.awvalid = 1; axil.wvalid = 1; axil.arvalid = 1;
    @(negedge clk);
    hit = axil.awready && axil.wready && axil.arready;
    step();
    axil.awvalid = 0; axil.wvalid = 0; axil.arvalid = 0;
    n_chk++;
    if (!hit) $display("FAIL collision_handshake: got not ready want all ready");
    else n_pass++;
    axil.rready = 1; axil.bready = 1;
    @(negedge clk);
    gd = axil.rdata; gr = axil.rresp; rv = axil.rvalid; gb = axil.bresp; bv = axil.bvalid;
    step();
    axil.rready = 0; axil.bready = 0;
    n_chk++;
    if (exp_r.size() == 0 || exp_b.size() == 0) $display("FAIL collision_old_value: scoreboard empty");
    else begin
      logic [33:0] er; logic [1:0] eb;
      er = exp_r.pop_front(); eb = exp_b.pop_front();
      if (rv !== 1'b1 || bv !== 1'b1 || {gd, gr} !== er || gb !== eb)
        $display("FAIL collision_old_value: got rv=%b bv=%b %h/%b b=%b want 1 1 %h/%b b=%b",
                 rv, bv, gd, gr, gb, er[33:2], er[1:0], eb);
      else n_pass++;
    end
    axil_read(32'h08, 32'h5555_5555, 2'b00, 0, 0, "collision_new_value");
  endtask

  task automatic test_reset_mid();
    axil.awaddr = 32'h08; axil.awvalid = 1; axil.araddr = 32'h00; axil.arvalid = 1;
    step();
    axil.awvalid = 0; axil.arvalid = 0;
    step();
    rst_n = 0;
    #1;
    n_chk++;
    if ({axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid} !== 5'b0 || user_ctrl !== 2'b0)
      $display("FAIL reset_mid_outputs: got %b ctrl=%b want 00000 ctrl=00",
               {axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid}, user_ctrl);
    else n_pass++;
    step(); step();
    rst_n = 1;
    step();
    n_chk++;
    if ({axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid} !== 5'b11100)
      $display("FAIL reset_mid_idle: got %b want 11100",
               {axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid});
    else n_pass++;
    axil_read(32'h08, 32'h0, 2'b00, 0, 0, "reset_mid_scratch");
  endtask

  task automatic test_counter();
    rst_n = 0; step(); step();
    rst_n = 1;
    axil_read(32'h18, 32'h0, 2'b00, 0, 1, "cycle_lo_pre_wrap");
    axil_read(32'h1C, 32'h0, 2'b00, 0, 0, "cycle_hi_pre_wrap");
    repeat (30) step();
    axil_read(32'h18, 32'h0, 2'b00, 10, 1, "cycle_lo_post_wrap");
    axil_read(32'h1C, 32'h1, 2'b00, 10, 0, "cycle_hi_snapshot");
  endtask

  initial begin
    test_reset();
    test_id_version();
    test_scratch();
    test_back_to_back();
    test_control();
    test_cattrip();
    test_temp();
    test_decode_err();
    test_rw_collision();
    test_reset_mid();
    test_counter();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish before 500000");
    $fatal(1, "timeout");
  end
endmodule
